// File: rtl/packet_fifo_axis_out.sv
// Drains complete packets from a fwft packet FIFO (eop in the word MSB) onto an
// AXI-Stream master through a 2-entry skid buffer, truncating oversize packets.
//
// state   | meaning
// IDLE    | between packets; waits for enable and a complete stored packet
// XFER    | reading words into the skid buffer
// DISCARD | popping and dropping the tail of an oversize packet up to its eop
module packet_fifo_axis_out #(
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_PKT_LEN = 64,
   parameter int LEN_WIDTH   = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_data_empty,
   input  logic                  fifo_pkt_empty,
   output logic                  fifo_ren,
   output logic [DATA_WIDTH-2:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  err_len,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, XFER, DISCARD} state_t;

   localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(MAX_PKT_LEN - 1);

   state_t                state;
   logic [1:0]            occ;
   logic [1:0]            occ_next;
   logic [DATA_WIDTH-2:0] data1;
   logic                  last1;
   logic [LEN_WIDTH-1:0]  word_cnt;
   logic                  eop;
   logic                  at_max;
   logic                  new_last;
   logic                  push;
   logic                  pop;

   assign eop      = fifo_rdata[DATA_WIDTH-1];
   assign at_max   = (word_cnt == LAST_IDX);
   assign new_last = eop | at_max;
   assign push     = (state == XFER) && fifo_ren;
   assign pop      = m_axis_tvalid && m_axis_tready;
   assign busy     = (state != IDLE) || (occ != 2'd0);

   always_comb begin
      fifo_ren = 1'b0;
      case (state)
         XFER:    fifo_ren = !fifo_data_empty && (occ != 2'd2);
         DISCARD: fifo_ren = !fifo_data_empty;
         default: fifo_ren = 1'b0;
      endcase
   end

   always_comb begin
      occ_next = occ;
      if (push && !pop)
         occ_next = occ + 2'd1;
      else if (!push && pop)
         occ_next = occ - 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         word_cnt      <= '0;
         err_len       <= 1'b0;
         drop_cnt      <= '0;
         pkt_cnt       <= '0;
         occ           <= 2'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         data1         <= '0;
         last1         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && !fifo_pkt_empty) begin
                  state    <= XFER;
                  word_cnt <= '0;
               end
            end
            XFER: begin
               if (push) begin
                  word_cnt <= word_cnt + LEN_WIDTH'(1);
                  if (eop) begin
                     state <= IDLE;
                  end else if (at_max) begin
                     state    <= DISCARD;
                     err_len  <= 1'b1;
                     drop_cnt <= drop_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            DISCARD: begin
               if (fifo_ren && eop)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (pop && m_axis_tlast)
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);

         // push is blocked at occupancy 2, so push+pop only happens with one entry held
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  m_axis_tdata <= fifo_rdata[DATA_WIDTH-2:0];
                  m_axis_tlast <= new_last;
               end else begin
                  data1 <= fifo_rdata[DATA_WIDTH-2:0];
                  last1 <= new_last;
               end
            end
            2'b01: begin
               if (occ == 2'd2) begin
                  m_axis_tdata <= data1;
                  m_axis_tlast <= last1;
               end
            end
            2'b11: begin
               m_axis_tdata <= fifo_rdata[DATA_WIDTH-2:0];
               m_axis_tlast <= new_last;
            end
            default: ;
         endcase

         occ           <= occ_next;
         m_axis_tvalid <= (occ_next != 2'd0);
      end
   end

endmodule

// File: tb/tb_packet_fifo_axis_out.sv
// Bench for packet_fifo_axis_out: a queue-based FIFO model feeds the DUT and a
// packet-level scoreboard predicts the AXI-Stream words, counters and error flag.
module tb_packet_fifo_axis_out;

   localparam int DW  = 32;
   localparam int MAX = 8;
   localparam int LW  = 16;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] fifo_rdata = '0;
   logic          fifo_data_empty = 1'b1;
   logic          fifo_pkt_empty = 1'b1;
   logic          fifo_ren;
   logic [DW-2:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b0;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] drop_cnt;
   logic          err_len;
   logic          busy;

   packet_fifo_axis_out #(
      .DATA_WIDTH (DW),
      .MAX_PKT_LEN(MAX),
      .LEN_WIDTH  (LW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .fifo_rdata     (fifo_rdata),
      .fifo_data_empty(fifo_data_empty),
      .fifo_pkt_empty (fifo_pkt_empty),
      .fifo_ren       (fifo_ren),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tready  (m_axis_tready),
      .pkt_cnt        (pkt_cnt),
      .drop_cnt       (drop_cnt),
      .err_len        (err_len),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // tag per FIFO word: 0 = delivered, 1 = delivered as truncation point, 2 = discarded
   logic [DW-1:0] fq[$];
   int            tq[$];
   logic [DW-1:0] pend[$];
   int            pend_tag[$];
   logic [DW-1:0] exp_q[$];
   int            ren_cycles[$];
   int            out_cycles[$];

   int            occ = 0;
   logic [CW-1:0] ref_pkt = '0;
   logic [CW-1:0] ref_drop = '0;
   logic          ref_err = 1'b0;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            tr_mode = 0;
   bit            trickle_en = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-2:0] prev_d = '0;
   logic          prev_l = 1'b0;

   function automatic void apply_fifo();
      int n;
      n = 0;
      foreach (fq[i]) if (fq[i][DW-1]) n++;
      fifo_data_empty = (fq.size() == 0);
      fifo_pkt_empty  = (n == 0);
      fifo_rdata      = (fq.size() != 0) ? fq[0] : '0;
   endfunction

   task automatic make_pkt(input int len, input bit slow);
      logic [DW-2:0] pl;
      logic          eop;
      int            tag;
      for (int i = 0; i < len; i++) begin
         pl  = (DW-1)'($urandom);
         eop = (i == len - 1);
         if (i < MAX - 1)       tag = 0;
         else if (i == MAX - 1) tag = (len > MAX) ? 1 : 0;
         else                   tag = 2;
         if (slow) begin
            pend.push_back({eop, pl});
            pend_tag.push_back(tag);
         end else begin
            fq.push_back({eop, pl});
            tq.push_back(tag);
         end
         if (tag != 2) exp_q.push_back({pl, (eop || tag == 1)});
      end
      apply_fifo();
   endtask

   task automatic move_pend(input int n);
      for (int i = 0; i < n && pend.size() != 0; i++) begin
         fq.push_back(pend.pop_front());
         tq.push_back(pend_tag.pop_front());
      end
      apply_fifo();
   endtask

   // One clock: observe at negedge, then update FIFO model and tready after posedge.
   task automatic cycle();
      bit ren;
      int tag;
      @(negedge clk);
      cyc++;
      checks++;
      if (m_axis_tvalid !== (occ != 0)) begin
         errors++;
         $display("FAIL tvalid_occ: tvalid=%b required %b (model occupancy %0d) cyc %0d", m_axis_tvalid, (occ != 0), occ, cyc);
      end
      checks++;
      if (pkt_cnt !== ref_pkt || drop_cnt !== ref_drop || err_len !== ref_err) begin
         errors++;
         $display("FAIL stats: pkt=%0d drop=%0d err=%b required pkt=%0d drop=%0d err=%b cyc %0d", pkt_cnt, drop_cnt, err_len, ref_pkt, ref_drop, ref_err, cyc);
      end
      if (prev_stall) begin
         checks++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
            errors++;
            $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b cyc %0d", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l, cyc);
         end
      end
      if (occ == 2 && tq.size() != 0 && tq[0] != 2) begin
         checks++;
         if (fifo_ren !== 1'b0) begin
            errors++;
            $display("FAIL ren_when_full: fifo_ren=%b required 0 cyc %0d", fifo_ren, cyc);
         end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got data=%h last=%b required no word cyc %0d", m_axis_tdata, m_axis_tlast, cyc);
         end else begin
            if ({m_axis_tdata, m_axis_tlast} !== exp_q[0]) begin
               errors++;
               $display("FAIL out_word: got data=%h last=%b required data=%h last=%b cyc %0d", m_axis_tdata, m_axis_tlast, exp_q[0][DW-1:1], exp_q[0][0], cyc);
            end
            void'(exp_q.pop_front());
         end
         occ--;
         if (m_axis_tlast) ref_pkt++;
         out_cycles.push_back(cyc);
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      ren = (fifo_ren === 1'b1);
      if (ren) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ren_on_empty: fifo_ren=1 required 0 cyc %0d", cyc);
            ren = 1'b0;
         end else begin
            tag = tq[0];
            if (tag != 2) occ++;
            if (tag == 1) begin
               ref_drop++;
               ref_err = 1'b1;
            end
            ren_cycles.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
      if (ren) begin
         void'(fq.pop_front());
         void'(tq.pop_front());
      end
      if (trickle_en && pend.size() != 0 && $urandom_range(0, 2) != 0) move_pend(1);
      case (tr_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = (cyc % 3 == 0);
         3: m_axis_tready = 1'b0;
         default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      apply_fifo();
   endtask

   task automatic drain(input int budget, input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         cycle();
         done = (exp_q.size() == 0) && (fq.size() == 0) && (pend.size() == 0) && (busy === 1'b0);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_%s: timeout exp_left=%0d fifo_left=%0d busy=%b required all drained", name, exp_q.size(), fq.size(), busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      apply_fifo();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, fifo_ren, err_len, busy} !== 5'b0 || m_axis_tdata !== '0 || pkt_cnt !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b last=%b ren=%b err=%b busy=%b data=%h pkt=%0d drop=%0d required all 0", m_axis_tvalid, m_axis_tlast, fifo_ren, err_len, busy, m_axis_tdata, pkt_cnt, drop_cnt);
      end
      rst_n = 1'b1;
      enable = 1'b1;
      tr_mode = 0;
      repeat (2) cycle();
   endtask

   task automatic test_single();
      logic [CW-1:0] base;
      bit ok;
      base = ref_pkt;
      ren_cycles.delete();
      out_cycles.delete();
      tr_mode = 0;
      m_axis_tready = 1'b1;
      make_pkt(4, 1'b0);
      drain(40, "single");
      checks++;
      if (ren_cycles.size() != 4) begin
         errors++;
         $display("FAIL single_ren_count: got %0d read cycles required 4", ren_cycles.size());
      end
      ok = (ren_cycles.size() == 4) && (out_cycles.size() == 4);
      if (ok) for (int i = 0; i < 4; i++) begin
         if (out_cycles[i] != ren_cycles[i] + 1) ok = 1'b0;
         if (i > 0 && ren_cycles[i] != ren_cycles[i-1] + 1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_latency: reads=%p outs=%p required 4 consecutive reads each output 1 cycle later", ren_cycles, out_cycles);
      end
      checks++;
      if (pkt_cnt !== base + CW'(1) || err_len !== 1'b0) begin
         errors++;
         $display("FAIL single_stats: pkt=%0d err=%b required pkt=%0d err=0", pkt_cnt, err_len, base + CW'(1));
      end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] base;
      bit ok;
      base = ref_pkt;
      ren_cycles.delete();
      tr_mode = 0;
      make_pkt(3, 1'b0);
      make_pkt(3, 1'b0);
      drain(60, "b2b");
      ok = (ren_cycles.size() == 6);
      if (ok) ok = (ren_cycles[1] == ren_cycles[0] + 1) && (ren_cycles[2] == ren_cycles[1] + 1) &&
                   (ren_cycles[3] == ren_cycles[2] + 2) && (ren_cycles[4] == ren_cycles[3] + 1) &&
                   (ren_cycles[5] == ren_cycles[4] + 1);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_gap: reads=%p required 3+3 consecutive reads with exactly one idle cycle between", ren_cycles);
      end
      checks++;
      if (pkt_cnt !== base + CW'(2)) begin
         errors++;
         $display("FAIL b2b_pkt_cnt: got %0d required %0d", pkt_cnt, base + CW'(2));
      end
   endtask

   task automatic test_backpressure();
      logic [CW-1:0] base;
      base = ref_pkt;
      tr_mode = 1;
      make_pkt(5, 1'b0);
      drain(100, "backpressure");
      checks++;
      if (pkt_cnt !== base + CW'(1)) begin
         errors++;
         $display("FAIL bp_pkt_cnt: got %0d required %0d", pkt_cnt, base + CW'(1));
      end
   endtask

   task automatic test_exact_max();
      tr_mode = 2;
      make_pkt(MAX, 1'b0);
      drain(100, "exact_max");
      checks++;
      if (err_len !== 1'b0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL exact_max: err=%b drop=%0d required err=0 drop=0", err_len, drop_cnt);
      end
   endtask

   task automatic test_oversize();
      logic [CW-1:0] base;
      logic [CW-1:0] base_drop;
      base = ref_pkt;
      base_drop = ref_drop;
      tr_mode = 0;
      make_pkt(12, 1'b0);
      make_pkt(2, 1'b0);
      drain(100, "oversize");
      checks++;
      if (err_len !== 1'b1 || drop_cnt !== base_drop + CW'(1) || pkt_cnt !== base + CW'(2)) begin
         errors++;
         $display("FAIL oversize_stats: err=%b drop=%0d pkt=%0d required err=1 drop=%0d pkt=%0d", err_len, drop_cnt, pkt_cnt, base_drop + CW'(1), base + CW'(2));
      end
   endtask

   task automatic test_gating();
      logic [CW-1:0] base;
      tr_mode = 0;
      trickle_en = 1'b0;
      make_pkt(4, 1'b1);
      move_pend(3);
      ren_cycles.delete();
      repeat (6) cycle();
      checks++;
      if (ren_cycles.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL partial_gate: reads=%0d busy=%b required 0 reads and busy=0", ren_cycles.size(), busy);
      end
      move_pend(1);
      drain(40, "partial");

      base = ref_pkt;
      make_pkt(6, 1'b0);
      make_pkt(2, 1'b0);
      repeat (2) cycle();
      enable = 1'b0;
      repeat (20) cycle();
      checks++;
      if (fq.size() != 2 || exp_q.size() != 2 || busy !== 1'b0 || pkt_cnt !== base + CW'(1)) begin
         errors++;
         $display("FAIL enable_gate: fifo_left=%0d exp_left=%0d busy=%b pkt=%0d required 2 2 0 %0d", fq.size(), exp_q.size(), busy, pkt_cnt, base + CW'(1));
      end
      enable = 1'b1;
      drain(40, "enable");
      checks++;
      if (pkt_cnt !== base + CW'(2)) begin
         errors++;
         $display("FAIL enable_resume: pkt=%0d required %0d", pkt_cnt, base + CW'(2));
      end
   endtask

   task automatic test_random();
      trickle_en = 1'b1;
      tr_mode = 2;
      for (int p = 0; p < 20; p++) make_pkt($urandom_range(1, 12), 1'b1);
      drain(3000, "random");
      trickle_en = 1'b0;
      checks++;
      if (pkt_cnt !== ref_pkt || drop_cnt !== ref_drop || err_len !== ref_err) begin
         errors++;
         $display("FAIL random_stats: pkt=%0d drop=%0d err=%b required %0d %0d %b", pkt_cnt, drop_cnt, err_len, ref_pkt, ref_drop, ref_err);
      end
   endtask

   task automatic test_async_reset();
      tr_mode = 3;
      make_pkt(5, 1'b0);
      repeat (4) cycle();
      checks++;
      if (m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_valid: tvalid=%b required 1", m_axis_tvalid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, fifo_ren, err_len, busy} !== 5'b0 || m_axis_tdata !== '0 || pkt_cnt !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b last=%b ren=%b err=%b busy=%b data=%h pkt=%0d drop=%0d required all 0", m_axis_tvalid, m_axis_tlast, fifo_ren, err_len, busy, m_axis_tdata, pkt_cnt, drop_cnt);
      end
      fq.delete();
      tq.delete();
      pend.delete();
      pend_tag.delete();
      exp_q.delete();
      occ = 0;
      ref_pkt = '0;
      ref_drop = '0;
      ref_err = 1'b0;
      prev_stall = 1'b0;
      apply_fifo();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tr_mode = 0;
      m_axis_tready = 1'b1;
      enable = 1'b1;
      make_pkt(1, 1'b0);
      drain(40, "post_reset");
      checks++;
      if (pkt_cnt !== CW'(1) || err_len !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_pkt: pkt=%0d err=%b required pkt=1 err=0", pkt_cnt, err_len);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_exact_max();
      test_oversize();
      test_gating();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/packet_fifo_axis_out.md
Name: packet_fifo_axis_out

Overview:
Downstream drain stage for the packet FIFO (fwft, eop carried in the data MSB). It starts reading only when at least one complete packet is stored. It converts the FIFO words into an AXI-Stream master with tvalid/tready/tlast, using a 2-entry output skid buffer. It also enforces a maximum packet length, truncating and discarding oversize packets, and keeps packet and drop statistics.

Parameters:
DATA_WIDTH, 32, FIFO word width; bit DATA_WIDTH-1 is eop, bits DATA_WIDTH-2:0 are payload
MAX_PKT_LEN, 64, maximum words per packet (>=2)
LEN_WIDTH, 16, width of the internal word counter (must hold MAX_PKT_LEN)
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new packets to start; sampled only at packet boundaries
fifo_rdata  in  DATA_WIDTH  fwft head word from packet FIFO
fifo_data_empty  in  1  high = no word stored
fifo_pkt_empty  in  1  high = no complete (eop-terminated) packet stored
fifo_ren  out  1  read/pop strobe to packet FIFO (combinational)
m_axis_tdata  out  DATA_WIDTH-1  payload
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last word of packet
m_axis_tready  in  1  downstream ready
pkt_cnt  out  CNT_WIDTH  packets fully sent (tlast handshake), wraps
drop_cnt  out  CNT_WIDTH  oversize packets truncated, wraps
err_len  out  1  sticky: an oversize packet was seen; cleared only by reset
busy  out  1  high while state != IDLE or skid buffer is non-empty

Behaviour:
- Reset (rst_n low, async): state=IDLE, skid occupancy=0, m_axis_tvalid=0, tdata=0, tlast=0, pkt_cnt=0, drop_cnt=0, err_len=0, word counter=0. fifo_ren=0 while in reset. Reset mid-packet abandons the packet; the FIFO is reset alongside this block.
- FSM states: IDLE, XFER, DISCARD.
- IDLE -> XFER when enable=1 and fifo_pkt_empty=0; word counter cleared.
- XFER:
  - fifo_ren = !fifo_data_empty && (occupancy<2).
  - Each read word is pushed into the skid buffer with tlast = eop bit, and the word counter increments.
  - Read word with eop=1 -> IDLE.
  - Read word that is the MAX_PKT_LEN-th word with eop=0: push it with tlast forced to 1, set err_len=1, increment drop_cnt, go to DISCARD.
  - fifo_data_empty=1 mid-packet: stall with no read and no state change.
- DISCARD:
  - fifo_ren = !fifo_data_empty. Words are popped but not pushed into the skid buffer.
  - Word with eop=1 popped -> IDLE.
- Packet gap: IDLE re-evaluates fifo_pkt_empty in the cycle after the eop read. This allows the FIFO flag update, so there is a minimum 1-cycle bubble between packets on the read side.
- Skid buffer (2 entries, FIFO order):
  - Registered outputs; the head entry drives m_axis_*.
  - tvalid = occupancy!=0.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Latency: a word read at cycle t appears on m_axis at t+1 if the buffer was empty.
  - tdata/tlast must hold stable while tvalid=1 and tready=0.
- Full throughput: 1 word/clk within a packet when tready is held at 1.
- enable=0 mid-packet has no effect until the packet completes; no new packet starts.
- pkt_cnt increments on tvalid&tready&tlast, including truncated packets.
- Counters wrap from all-ones to 0.
- A word with eop=1 as the MAX_PKT_LEN-th word is a legal packet: no error.

Test Plan:
- Single 4-word packet, eop on word 3, tready=1 -> fifo_ren high 4 cycles; tvalid on cycles t+1..t+4 with tlast on 4th word; pkt_cnt=1, err_len=0.
- Two back-to-back 3-word packets, tready=1 -> 6 words out in order, exactly one idle cycle between the packets on the read side; pkt_cnt=2.
- Backpressure: 5-word packet, tready toggles 1,0,0,1,... -> occupancy never exceeds 2; no word lost or duplicated; tdata stable during stalls; fifo_ren=0 whenever occupancy=2.
- Oversize: MAX_PKT_LEN=8, 12-word packet followed by a 2-word packet -> 8 words out with tlast on the 8th, 4 words discarded; err_len=1, drop_cnt=1; the next packet is delivered intact; pkt_cnt=2.
- Gating: fifo_data_empty=0 but fifo_pkt_empty=1 (partial packet) -> fifo_ren stays 0. Deassert enable mid-packet -> current packet completes and no new start until enable=1.
- Async reset asserted mid-packet with tvalid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release with a fresh 1-word eop packet -> normal delivery, pkt_cnt=1.
